// File: rtl/sdram_cmd_sequencer_pkg.sv
// Shared definitions for the SDRAM command sequencer: command codes understood by
// memory_interface and the sequencer state encoding.
package sdram_cmd_sequencer_pkg;

   typedef enum logic [3:0] {
      CMD_DESL  = 4'h0,
      CMD_NOP   = 4'h1,
      CMD_MRS   = 4'h2,
      CMD_ACT   = 4'h3,
      CMD_READ  = 4'h4,
      CMD_READA = 4'h5,
      CMD_WRIT  = 4'h6,
      CMD_WRITA = 4'h7,
      CMD_PRE   = 4'h8,
      CMD_PALL  = 4'h9,
      CMD_BST   = 4'hA,
      CMD_REF   = 4'hB,
      CMD_SELF  = 4'hC,
      CMD_SUP   = 4'hD,
      CMD_REC   = 4'hE
   } cmd_e;

   typedef enum logic [3:0] {
      ST_INIT_WAIT = 4'd0,
      ST_INIT_PRE  = 4'd1,
      ST_INIT_REF  = 4'd2,
      ST_INIT_MRD  = 4'd3,
      ST_IDLE      = 4'd4,
      ST_REF       = 4'd5,
      ST_RCD       = 4'd6,
      ST_CAS       = 4'd7,
      ST_RD_OUT    = 4'd8,
      ST_RP        = 4'd9,
      ST_WRP       = 4'd10
   } state_e;

endpackage

// File: rtl/sdram_cmd_sequencer_if.sv
// Host request/response and SDRAM command/data bundle; master = host side, slave = sequencer.
interface sdram_cmd_sequencer_if;
   import sdram_cmd_sequencer_pkg::*;

   logic        req;
   logic        req_we;
   logic [21:0] req_addr;
   logic [1:0]  req_be;
   logic [15:0] req_wdata;
   logic        req_ready;
   logic        rd_valid;
   logic [15:0] rd_data;
   logic        init_done;
   cmd_e        command;
   logic [11:0] mrs;
   logic [21:0] addr_out;
   logic [1:0]  be_out;
   logic [15:0] dq_out;
   logic        dq_oe;
   logic [15:0] dq_in;

   modport master (
      output req, req_we, req_addr, req_be, req_wdata, dq_in,
      input  req_ready, rd_valid, rd_data, init_done, command, mrs, addr_out, be_out, dq_out, dq_oe
   );

   modport slave (
      input  req, req_we, req_addr, req_be, req_wdata, dq_in,
      output req_ready, rd_valid, rd_data, init_done, command, mrs, addr_out, be_out, dq_out, dq_oe
   );

endinterface

// File: rtl/sdram_cmd_sequencer_refresh_timer.sv
// Free-running refresh interval timer with a sticky single-entry refresh request flag.
module sdram_cmd_sequencer_refresh_timer #(
   parameter int REF_INTERVAL = 780
) (
   input  logic clk,
   input  logic rst,
   input  logic en,
   input  logic clr,
   output logic pending,
   output logic pending_next
);

   localparam int TW = $clog2(REF_INTERVAL);

   logic [TW-1:0] cnt_r;
   logic          pending_r;
   logic          wrap_s;

   assign wrap_s = en && (cnt_r == TW'(REF_INTERVAL - 1));

   // A wrap landing on the clearing cycle still requests a refresh, so none is lost.
   always_comb begin
      if (wrap_s) begin
         pending_next = 1'b1;
      end else if (clr) begin
         pending_next = 1'b0;
      end else begin
         pending_next = pending_r;
      end
   end

   // Interval counter and request flag
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cnt_r     <= '0;
         pending_r <= 1'b0;
      end else begin
         if (wrap_s) begin
            cnt_r <= '0;
         end else if (en) begin
            cnt_r <= cnt_r + TW'(1);
         end else begin
            cnt_r <= cnt_r;
         end
         pending_r <= pending_next;
      end
   end

   assign pending = pending_r;

endmodule

// File: rtl/sdram_cmd_sequencer.sv
// SDRAM command sequencer: power-up init, periodic auto-refresh and single-word
// host reads/writes via ACT + READA/WRITA, with every output registered.
module sdram_cmd_sequencer
   import sdram_cmd_sequencer_pkg::*;
#(
   parameter int          T_INIT       = 10000,
   parameter int          INIT_REFS    = 8,
   parameter int          T_RP         = 2,
   parameter int          T_RFC        = 7,
   parameter int          T_MRD        = 2,
   parameter int          T_RCD        = 2,
   parameter int          CAS_LAT      = 2,
   parameter int          T_WRP        = 3,
   parameter int          REF_INTERVAL = 780,
   parameter logic [11:0] MRS_VALUE    = 12'h020
) (
   input logic                  clk,
   input logic                  rst,
   sdram_cmd_sequencer_if.slave bus
);

   localparam int CW = $clog2(T_INIT + 1);
   localparam int RW = (INIT_REFS > 1) ? $clog2(INIT_REFS) : 1;

   state_e        state_r, state_s;
   logic [CW-1:0] cnt_r, cnt_s;
   logic [RW-1:0] ref_cnt_r, ref_cnt_s;
   logic          lat_we_r, lat_we_s;
   logic [1:0]    lat_be_r, lat_be_s;
   logic [15:0]   lat_wdata_r, lat_wdata_s;
   logic [15:0]   cap_r, cap_s;
   cmd_e          command_r, command_s;
   logic [21:0]   addr_out_r, addr_out_s;
   logic [1:0]    be_out_r, be_out_s;
   logic [15:0]   dq_out_r, dq_out_s;
   logic          dq_oe_r, dq_oe_s;
   logic          req_ready_r, req_ready_s;
   logic          rd_valid_r, rd_valid_s;
   logic [15:0]   rd_data_r, rd_data_s;
   logic          init_done_r, init_done_s;
   logic          ref_clr_s, ref_pending_s, ref_pending_next_s;

   sdram_cmd_sequencer_refresh_timer #(
      .REF_INTERVAL(REF_INTERVAL)
   ) u_refresh_timer (
      .clk         (clk),
      .rst         (rst),
      .en          (init_done_r),
      .clr         (ref_clr_s),
      .pending     (ref_pending_s),
      .pending_next(ref_pending_next_s)
   );

   // Each command loads cnt with (delay-1); the next step fires when cnt reaches zero.
   always_comb begin
      state_s     = state_r;
      cnt_s       = cnt_r;
      ref_cnt_s   = ref_cnt_r;
      lat_we_s    = lat_we_r;
      lat_be_s    = lat_be_r;
      lat_wdata_s = lat_wdata_r;
      cap_s       = cap_r;
      command_s   = CMD_NOP;
      addr_out_s  = addr_out_r;
      be_out_s    = 2'b11;
      dq_out_s    = 16'h0000;
      dq_oe_s     = 1'b0;
      rd_valid_s  = 1'b0;
      rd_data_s   = rd_data_r;
      init_done_s = init_done_r;
      ref_clr_s   = 1'b0;
      case (state_r)
         ST_INIT_WAIT: begin
            if (cnt_r == CW'(T_INIT)) begin
               command_s = CMD_PALL;
               cnt_s     = CW'(T_RP - 1);
               state_s   = ST_INIT_PRE;
            end else begin
               cnt_s = cnt_r + CW'(1);
            end
         end
         ST_INIT_PRE: begin
            if (cnt_r == '0) begin
               command_s = CMD_REF;
               cnt_s     = CW'(T_RFC - 1);
               state_s   = ST_INIT_REF;
            end else begin
               cnt_s = cnt_r - CW'(1);
            end
         end
         ST_INIT_REF: begin
            if (cnt_r != '0) begin
               cnt_s = cnt_r - CW'(1);
            end else if (ref_cnt_r == RW'(INIT_REFS - 1)) begin
               command_s = CMD_MRS;
               cnt_s     = CW'(T_MRD - 1);
               state_s   = ST_INIT_MRD;
            end else begin
               command_s = CMD_REF;
               ref_cnt_s = ref_cnt_r + RW'(1);
               cnt_s     = CW'(T_RFC - 1);
            end
         end
         ST_INIT_MRD: begin
            if (cnt_r == '0) begin
               init_done_s = 1'b1;
               state_s     = ST_IDLE;
            end else begin
               cnt_s = cnt_r - CW'(1);
            end
         end
         ST_IDLE: begin
            if (ref_pending_s) begin
               command_s = CMD_REF;
               ref_clr_s = 1'b1;
               cnt_s     = CW'(T_RFC - 1);
               state_s   = ST_REF;
            end else if (bus.req && req_ready_r) begin
               command_s   = CMD_ACT;
               addr_out_s  = bus.req_addr;
               lat_we_s    = bus.req_we;
               lat_be_s    = bus.req_be;
               lat_wdata_s = bus.req_wdata;
               cnt_s       = CW'(T_RCD - 1);
               state_s     = ST_RCD;
            end else begin
               state_s = ST_IDLE;
            end
         end
         ST_REF: begin
            if (cnt_r == '0) begin
               state_s = ST_IDLE;
            end else begin
               cnt_s = cnt_r - CW'(1);
            end
         end
         ST_RCD: begin
            if (cnt_r != '0) begin
               cnt_s = cnt_r - CW'(1);
            end else if (lat_we_r) begin
               command_s = CMD_WRITA;
               dq_oe_s   = 1'b1;
               dq_out_s  = lat_wdata_r;
               be_out_s  = ~lat_be_r;
               cnt_s     = CW'(T_WRP - 1);
               state_s   = ST_WRP;
            end else begin
               command_s = CMD_READA;
               be_out_s  = ~lat_be_r;
               cnt_s     = CW'(CAS_LAT - 1);
               state_s   = ST_CAS;
            end
         end
         ST_CAS: begin
            if (cnt_r == '0) begin
               cap_s   = bus.dq_in;
               state_s = ST_RD_OUT;
            end else begin
               cnt_s = cnt_r - CW'(1);
            end
         end
         ST_RD_OUT: begin
            rd_valid_s = 1'b1;
            rd_data_s  = cap_r;
            cnt_s      = CW'(T_RP - 1);
            state_s    = ST_RP;
         end
         ST_RP, ST_WRP: begin
            if (cnt_r == '0) begin
               addr_out_s = 22'h000000;
               state_s    = ST_IDLE;
            end else begin
               cnt_s = cnt_r - CW'(1);
            end
         end
         default: begin
            cnt_s   = '0;
            state_s = ST_INIT_WAIT;
         end
      endcase
      // Uses next-cycle values so ready is never high in a cycle where refresh wins.
      req_ready_s = (state_s == ST_IDLE) && init_done_s && !ref_pending_next_s;
   end

   // State, counters, latched request and registered outputs
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_r     <= ST_INIT_WAIT;
         cnt_r       <= '0;
         ref_cnt_r   <= '0;
         lat_we_r    <= 1'b0;
         lat_be_r    <= 2'b00;
         lat_wdata_r <= 16'h0000;
         cap_r       <= 16'h0000;
         command_r   <= CMD_NOP;
         addr_out_r  <= 22'h000000;
         be_out_r    <= 2'b11;
         dq_out_r    <= 16'h0000;
         dq_oe_r     <= 1'b0;
         req_ready_r <= 1'b0;
         rd_valid_r  <= 1'b0;
         rd_data_r   <= 16'h0000;
         init_done_r <= 1'b0;
      end else begin
         state_r     <= state_s;
         cnt_r       <= cnt_s;
         ref_cnt_r   <= ref_cnt_s;
         lat_we_r    <= lat_we_s;
         lat_be_r    <= lat_be_s;
         lat_wdata_r <= lat_wdata_s;
         cap_r       <= cap_s;
         command_r   <= command_s;
         addr_out_r  <= addr_out_s;
         be_out_r    <= be_out_s;
         dq_out_r    <= dq_out_s;
         dq_oe_r     <= dq_oe_s;
         req_ready_r <= req_ready_s;
         rd_valid_r  <= rd_valid_s;
         rd_data_r   <= rd_data_s;
         init_done_r <= init_done_s;
      end
   end

   assign bus.command   = command_r;
   assign bus.mrs       = MRS_VALUE;
   assign bus.addr_out  = addr_out_r;
   assign bus.be_out    = be_out_r;
   assign bus.dq_out    = dq_out_r;
   assign bus.dq_oe     = dq_oe_r;
   assign bus.req_ready = req_ready_r;
   assign bus.rd_valid  = rd_valid_r;
   assign bus.rd_data   = rd_data_r;
   assign bus.init_done = init_done_r;

endmodule
